// File: rtl/fold_rr_scheduler.sv
// Round-robin front end that time-shares one combinational XOR-fold unit between
// NREQ requesters, capturing operands, issuing the fold and returning a tagged result.
//
// state | meaning
// IDLE  | no result held; accept slot for the next round-robin winner
// FOLD  | captured operands driven onto fu_a/fu_b; fold result registered this cycle
// OUT   | result presented with out_valid; accept slot when out_ready is high
module fold_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      fu_a,
  output logic [W-1:0]      fu_b,
  input  logic [W/2-1:0]    fu_aa,
  input  logic [W/2-1:0]    fu_bb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W/2-1:0]    out_aa,
  output logic [W/2-1:0]    out_bb,
  output logic [IDW-1:0]    out_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [IDW-1:0] op_id;

  logic           found;
  logic [IDW-1:0] win;
  logic           accept_slot;
  logic           grant;
  logic [W-1:0]   win_a;
  logic [W-1:0]   win_b;

  // Search starts just after the last winner and wraps, so the last winner has lowest priority.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (int'(rr_ptr) + off) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign accept_slot = (state == IDLE) || ((state == OUT) && out_ready);
  // Reset masks the grant so no requester sees a handshake that will be discarded.
  assign grant       = found && accept_slot && !rst;
  assign win_a       = req_a[int'(win)*W +: W];
  assign win_b       = req_b[int'(win)*W +: W];

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  // The fold tree only sees live operands during FOLD to keep it quiet otherwise.
  assign fu_a = (state == FOLD) ? op_a : '0;
  assign fu_b = (state == FOLD) ? op_b : '0;
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      out_valid <= 1'b0;
      out_aa    <= '0;
      out_bb    <= '0;
      out_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            op_a   <= win_a;
            op_b   <= win_b;
            op_id  <= win;
            rr_ptr <= win;
            state  <= FOLD;
          end
        end
        FOLD: begin
          out_aa    <= fu_aa;
          out_bb    <= fu_bb;
          out_id    <= op_id;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (grant) begin
              op_a   <= win_a;
              op_b   <= win_b;
              op_id  <= win;
              rr_ptr <= win;
              state  <= FOLD;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
